dmem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the 32-bit byte-write-enable data memory: accepts CPU load/store requests, drives the memory's en/we/addr/din, and consumes its 1-cycle synchronous-read dout.
- Generates byte lanes, aligns store data, and extracts plus sign/zero-extends load data.
- Splits misaligned accesses that cross a word boundary into two memory cycles.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/dmem_lsu.sv | 150 +++++++++++++++
 tb/tb_dmem_lsu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd2;

    localparam int unsigned LSU_MASK_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue0,
        StIssue1,
        StCapture,
        StResp
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_MASK_W-1:0] mask;
        logic [63:0]           data;
    } lsu_store_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store mask/data placement across two words and load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]            size,
    input  logic [1:0]            off,
    input  logic                  uns,
    input  logic [31:0]           wdata,
    input  logic [31:0]           hi,
    input  logic [31:0]           lo,
    output logic [LSU_MASK_W-1:0] mask8,
    output logic [63:0]           wide64,
    output logic                  split,
    output logic [31:0]           rdata
);

    function automatic lsu_store_t store_lanes(input logic [1:0] sz, input logic [1:0] o,
                                               input logic [31:0] d);
        lsu_store_t            s;
        logic [LSU_MASK_W-1:0] m;
        case (sz)
            LSU_BYTE: m = 8'h01;
            LSU_HALF: m = 8'h03;
            default:  m = 8'h0F;
        endcase
        s.mask = m << o;
        s.data = {32'b0, d} << {o, 3'b000};
        return s;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic [1:0] o,
                                                input logic u, input logic [31:0] h,
                                                input logic [31:0] l);
        logic [63:0] r64;
        logic [31:0] r;
        r64 = {h, l} >> {o, 3'b000};
        case (sz)
            LSU_BYTE: r = {{24{~u & r64[7]}}, r64[7:0]};
            LSU_HALF: r = {{16{~u & r64[15]}}, r64[15:0]};
            default:  r = r64[31:0];
        endcase
        return r;
    endfunction

    lsu_store_t st;

    always_comb begin
        st     = store_lanes(size, off, wdata);
        mask8  = st.mask;
        wide64 = st.data;
        split  = |st.mask[7:4];
        rdata  = load_extend(size, off, uns, hi, lo);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enabled synchronous data memory; splits
// word-crossing accesses into two memory cycles.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  dmem_en,
    output logic [3:0]            dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_din,
    input  logic [31:0]           dmem_dout
);

    lsu_state_e            state_q;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] w0_q;
    logic [31:0]           wdata_q;
    logic [31:0]           lo_q;
    logic [31:0]           rdata_q;

    logic [LSU_MASK_W-1:0] mask8;
    logic [63:0]           wide64;
    logic                  split;
    logic [31:0]           cap_hi;
    logic [31:0]           cap_lo;
    logic [31:0]           ld_result;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    // Unsplit loads see their only word on dout in CAPTURE; split loads saw the low word in ISSUE1.
    assign cap_hi = split ? dmem_dout : 32'b0;
    assign cap_lo = split ? lo_q : dmem_dout;

    lsu_align u_align (
        .size   (size_q),
        .off    (off_q),
        .uns    (uns_q),
        .wdata  (wdata_q),
        .hi     (cap_hi),
        .lo     (cap_lo),
        .mask8  (mask8),
        .wide64 (wide64),
        .split  (split),
        .rdata  (ld_result)
    );

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;

    always_comb begin
        dmem_en   = 1'b0;
        dmem_we   = 4'b0;
        dmem_addr = '0;
        dmem_din  = 32'b0;
        case (state_q)
            StIssue0: begin
                dmem_en   = 1'b1;
                dmem_addr = w0_q;
                if (we_q) begin
                    dmem_we  = mask8[3:0];
                    dmem_din = wide64[31:0];
                end
            end
            StIssue1: begin
                dmem_en   = 1'b1;
                dmem_addr = w0_q + ADDR_WIDTH'(1);
                if (we_q) begin
                    dmem_we  = mask8[7:4];
                    dmem_din = wide64[63:32];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b0;
            off_q   <= 2'b0;
            w0_q    <= '0;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        w0_q    <= req_addr[ADDR_WIDTH+1:2];
                        wdata_q <= req_wdata;
                        state_q <= StIssue0;
                    end
                end
                StIssue0: begin
                    if (split) begin
                        state_q <= StIssue1;
                    end else if (!we_q) begin
                        state_q <= StCapture;
                    end else begin
                        rdata_q <= 32'b0;
                        state_q <= StResp;
                    end
                end
                StIssue1: begin
                    if (we_q) begin
                        rdata_q <= 32'b0;
                        state_q <= StResp;
                    end else begin
                        lo_q    <= dmem_dout;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    rdata_q <= ld_result;
                    state_q <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu against a byte-addressed reference memory model.
module tb_dmem_lsu;

    localparam int unsigned AW     = 14;
    localparam int unsigned NWORDS = 1 << AW;
    localparam int unsigned NBYTES = NWORDS * 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          dmem_en;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout;

    int n_checks;
    int n_errors;

    logic [31:0] mem     [NWORDS];
    logic [7:0]  ref_mem [NBYTES];
    logic        init_mem;
    logic [31:0] last_rdata;

    logic [AW-1:0] obs_addr [$];
    logic [3:0]    obs_we   [$];
    logic [31:0]   obs_din  [$];

    dmem_lsu #(
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .dmem_en      (dmem_en),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_din     (dmem_din),
        .dmem_dout    (dmem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input int unsigned i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Synchronous-read, byte-write memory; every enabled access is logged.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= init_pat(i);
        end else if (dmem_en) begin
            obs_addr.push_back(dmem_addr);
            obs_we.push_back(dmem_we);
            obs_din.push_back(dmem_din);
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr][8*b+:8] <= dmem_din[8*b+:8];
            dmem_dout <= mem[dmem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit abort);
        int            n;
        int            cnt;
        int            lat;
        int            explat;
        int            ln;
        logic [AW+1:0] a;
        logic [AW-1:0] ea [2];
        logic [3:0]    ew [2];
        logic [31:0]   ed [2];
        logic [31:0]   val;
        logic [31:0]   exp_rd;
        logic [31:0]   got_rd;
        logic [31:0]   lmask;

        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        cnt = 0;
        val = '0;
        for (int k = 0; k < 2; k++) begin
            ea[k] = '0;
            ew[k] = '0;
            ed[k] = '0;
        end
        for (int i = 0; i < n; i++) begin
            a  = (AW + 2)'(addr + 32'(i));
            ln = int'(a[1:0]);
            if (cnt == 0 || a[AW+1:2] != ea[cnt-1]) begin
                ea[cnt] = a[AW+1:2];
                cnt++;
            end
            ew[cnt-1][ln]      = we;
            ed[cnt-1][8*ln+:8] = wdata[8*i+:8];
            val[8*i+:8]        = ref_mem[a];
            if (we && (!abort || cnt == 1)) ref_mem[a] = wdata[8*i+:8];
        end
        if (we) exp_rd = '0;
        else if (n == 1) exp_rd = {{24{~uns & val[7]}}, val[7:0]};
        else if (n == 2) exp_rd = {{16{~uns & val[15]}}, val[15:0]};
        else exp_rd = val;
        explat = (we ? 2 : 3) + (cnt - 1);

        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        check_eq("busy_ready", req_ready, 0);

        if (abort) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check_eq("abort_ready", req_ready, 1);
            check_eq("abort_mem", {dmem_en, dmem_we}, 0);
            check_eq("abort_rdata", resp_rdata, 0);
            lat = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                if (resp_valid) lat++;
            end
            rst = 1'b0;
            @(posedge clk);
            #1;
            if (resp_valid) lat++;
            check_eq("abort_no_resp", lat, 0);
            cnt = 1;
        end else begin
            lat    = 0;
            got_rd = '0;
            for (int c = 1; c <= 8; c++) begin
                if (resp_valid) begin
                    lat    = c;
                    got_rd = resp_rdata;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check_eq("latency", lat, explat);
            check_eq("rdata", got_rd, exp_rd);
            check_eq("resp_mem_idle", {dmem_en, dmem_we}, 0);
            @(posedge clk);
            #1;
            check_eq("pulse_end", resp_valid, 0);
            check_eq("ready_again", req_ready, 1);
            check_eq("rdata_hold", resp_rdata, exp_rd);
            last_rdata = got_rd;
        end

        check_eq("mem_cycles", obs_addr.size(), cnt);
        for (int k = 0; k < cnt && obs_addr.size() > 0; k++) begin
            lmask = {{8{ew[k][3]}}, {8{ew[k][2]}}, {8{ew[k][1]}}, {8{ew[k][0]}}};
            check_eq("mem_addr", obs_addr.pop_front(), ea[k]);
            check_eq("mem_we", obs_we[0], ew[k]);
            check_eq("mem_din", obs_din.pop_front() & lmask, ed[k] & lmask);
            void'(obs_we.pop_front());
        end
        obs_addr.delete();
        obs_we.delete();
        obs_din.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] low;

        n_checks     = 0;
        n_errors     = 0;
        last_rdata   = '0;
        rst          = 1'b1;
        init_mem     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < NWORDS; i++) begin
            r = init_pat(i);
            for (int b = 0; b < 4; b++) ref_mem[i*4+b] = r[8*b+:8];
        end
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_en", dmem_en, 0);
        check_eq("rst_we", dmem_we, 0);
        check_eq("rst_addr", dmem_addr, 0);
        check_eq("rst_din", dmem_din, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        check_eq("lw10_const", last_rdata, 32'hDEADBEEF);

        run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b0);
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        check_eq("lb13_const", last_rdata, 32'hFFFFFF80);
        run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        check_eq("lbu13_const", last_rdata, 32'h00000080);

        run_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h11223344, 1'b0);
        run_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0);
        check_eq("lw06_const", last_rdata, 32'h11223344);

        run_req(1'b1, 2'd2, 1'b0, 32'h00, 32'hAB000000, 1'b0);
        run_req(1'b1, 2'd2, 1'b0, 32'h04, 32'h000000CD, 1'b0);
        run_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 1'b0);
        check_eq("lh03_const", last_rdata, 32'hFFFFCDAB);
        run_req(1'b0, 2'd1, 1'b1, 32'h03, 32'h0, 1'b0);
        check_eq("lhu03_const", last_rdata, 32'h0000CDAB);

        run_req(1'b1, 2'd2, 1'b0, 32'hFFFE, 32'hCAFEF00D, 1'b0);
        run_req(1'b0, 2'd2, 1'b0, 32'h0001FFFE, 32'h0, 1'b0);
        check_eq("wrap_const", last_rdata, 32'hCAFEF00D);

        run_req(1'b1, 2'd2, 1'b0, 32'h21, 32'h55667788, 1'b1);
        run_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 1'b0);
        run_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0);

        for (int t = 0; t < 400; t++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) low = 16'hFFF0 + 16'($urandom_range(0, 15));
            else low = 16'($urandom_range(0, 63));
            run_req(1'($urandom), 2'($urandom), 1'($urandom), {r[31:16], low}, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                check_eq("gap_quiet", {resp_valid, dmem_en}, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
